// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Aligns load/store data, runs a single-outstanding
// bus request through a three-state FSM, tracks the LL/SC link bit and flags faults.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] excepttype_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] badvaddr_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i
);

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LL_OP  = 8'hF0;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;
    localparam logic [7:0] EXE_SC_OP  = 8'hF8;

    localparam logic [31:0] EXC_ADEL = 32'h0000_1000;
    localparam logic [31:0] EXC_ADES = 32'h0000_2000;
    localparam logic [31:0] EXC_BUS  = 32'h0000_4000;

    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        llbit_q, llbit_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic is_lb, is_lbu, is_lh, is_lhu, is_lw, is_ll;
    logic is_sb, is_sh, is_sw, is_sc;
    logic is_byte, is_half, is_word, is_load, is_store;
    logic misaligned, ade_l, ade_s, mem_op;

    assign is_lb  = (aluop_i == EXE_LB_OP);
    assign is_lbu = (aluop_i == EXE_LBU_OP);
    assign is_lh  = (aluop_i == EXE_LH_OP);
    assign is_lhu = (aluop_i == EXE_LHU_OP);
    assign is_lw  = (aluop_i == EXE_LW_OP);
    assign is_ll  = (aluop_i == EXE_LL_OP);
    assign is_sb  = (aluop_i == EXE_SB_OP);
    assign is_sh  = (aluop_i == EXE_SH_OP);
    assign is_sw  = (aluop_i == EXE_SW_OP);
    assign is_sc  = (aluop_i == EXE_SC_OP);

    assign is_byte  = is_lb | is_lbu | is_sb;
    assign is_half  = is_lh | is_lhu | is_sh;
    assign is_word  = is_lw | is_ll | is_sw | is_sc;
    assign is_load  = is_lb | is_lbu | is_lh | is_lhu | is_lw | is_ll;
    assign is_store = is_sb | is_sh | is_sw | is_sc;

    assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    assign ade_l      = is_load && misaligned;
    assign ade_s      = is_store && misaligned;

    // An SC without a live link completes locally as a failed conditional.
    assign mem_op = (is_load || is_store) && (excepttype_i == '0) && !misaligned
                    && !(is_sc && !llbit_q);

    // Big-endian lane select and store-data replication.
    logic [3:0]  sel_n;
    logic [31:0] wdata_n;

    // NOTE: every variable driven in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        sel_n   = 4'b1111;
        wdata_n = reg2_i;
        if (is_byte) begin
            wdata_n = {4{reg2_i[7:0]}};
            unique case (mem_addr_i[1:0])
                2'b00: sel_n = 4'b1000;
                2'b01: sel_n = 4'b0100;
                2'b10: sel_n = 4'b0010;
                2'b11: sel_n = 4'b0001;
            endcase
        end else if (is_half) begin
            wdata_n = {2{reg2_i[15:0]}};
            sel_n   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    always_comb begin
        unique case (mem_addr_i[1:0])
            2'b00: ld_byte = rdata_q[31:24];
            2'b01: ld_byte = rdata_q[23:16];
            2'b10: ld_byte = rdata_q[15:8];
            2'b11: ld_byte = rdata_q[7:0];
        endcase
        ld_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];

        load_data = rdata_q;
        if (is_lb) begin
            load_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (is_lbu) begin
            load_data = {24'h0, ld_byte};
        end else if (is_lh) begin
            load_data = {{16{ld_half[15]}}, ld_half};
        end else if (is_lhu) begin
            load_data = {16'h0, ld_half};
        end
    end

    logic [31:0] exc_v;
    logic        drop_bus;

    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; the state register below uses non-blocking '<=' only.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        llbit_d     = llbit_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        drop_bus    = 1'b0;

        wd_o         = wd_i;
        wreg_o       = 1'b0;
        wdata_o      = '0;
        stallreq_o   = 1'b0;
        exc_v        = excepttype_i | (ade_l ? EXC_ADEL : '0) | (ade_s ? EXC_ADES : '0);
        badvaddr_o   = (ade_l || ade_s) ? mem_addr_i : '0;
        excepttype_o = '0;

        unique case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stallreq_o  = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = sel_n;
                    bus_wdata_d = wdata_n;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    state_d     = S_ACCESS;
                end else if (!(ade_l || ade_s)) begin
                    wreg_o  = wreg_i;
                    wdata_o = is_sc ? '0 : wdata_i;
                end
            end

            S_ACCESS: begin
                stallreq_o = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                // An error, including one coincident with ack, beats the ack.
                if (bus_err_i || (cnt_q == TIMEOUT_LAST)) begin
                    err_d    = 1'b1;
                    drop_bus = 1'b1;
                    state_d  = S_DONE;
                end else if (bus_ack_i) begin
                    rdata_d  = bus_rdata_i;
                    drop_bus = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                if (err_q) begin
                    exc_v = exc_v | EXC_BUS;
                end else if (is_load) begin
                    wreg_o  = wreg_i;
                    wdata_o = load_data;
                    if (is_ll) begin
                        llbit_d = 1'b1;
                    end
                end else if (is_sc) begin
                    wreg_o  = wreg_i;
                    wdata_o = 32'd1;
                    llbit_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            err_d      = 1'b0;
            cnt_d      = '0;
            drop_bus   = 1'b1;
            stallreq_o = 1'b0;
            if (exc_v != '0) begin
                llbit_d = 1'b0;
            end
        end

        if (drop_bus) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_sel_d   = '0;
            bus_addr_d  = '0;
            bus_wdata_d = '0;
        end

        excepttype_o = exc_v;

        if (rst) begin
            wd_o         = '0;
            wreg_o       = 1'b0;
            wdata_o      = '0;
            stallreq_o   = 1'b0;
            excepttype_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            llbit_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            llbit_q     <= llbit_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Flush withdraws the request in the same cycle it arrives.
    assign bus_req_o   = bus_req_q & ~flush;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for mem_access; a driver queues expected results and
// a negedge monitor pops and compares them whenever the stage stops stalling.
module tb_mem_access;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LL  = 8'hF0;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_SC  = 8'hF8;
    localparam logic [7:0] OP_ADD = 8'h20;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, excepttype_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o, bus_req_o, bus_we_o;
    logic [31:0] wdata_o, excepttype_o, badvaddr_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i, bus_err_i;

    always #5 clk = ~clk;

    mem_access #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .excepttype_i(excepttype_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .excepttype_o(excepttype_o),
        .badvaddr_o(badvaddr_o), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
    );

    typedef struct {
        string       name;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] exc;
        logic [31:0] bad;
        int          stall;
        int          req;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [31:0] exc,
                                input logic [31:0] bad, input int stall, input int req,
                                input logic [3:0] sel, input logic we,
                                input logic [31:0] baddr, input logic [31:0] bwdata);
        exp_t e;
        e.name = n; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.exc = exc; e.bad = bad;
        e.stall = stall; e.req = req; e.sel = sel; e.we = we; e.baddr = baddr; e.bwdata = bwdata;
        return e;
    endfunction

    // Bus responder: ack (and err when err_mode) on the ack_lat-th cycle of a request.
    int          ack_lat   = 0;
    bit          err_mode  = 1'b0;
    logic [31:0] rdata_cfg = '0;
    int          resp_age  = 0;

    initial begin
        bus_ack_i   = 1'b0;
        bus_err_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req_o) begin
                resp_age++;
                bus_ack_i   = (ack_lat != 0) && (resp_age == ack_lat);
                bus_err_i   = bus_ack_i && err_mode;
                bus_rdata_i = bus_ack_i ? rdata_cfg : '0;
            end else begin
                resp_age    = 0;
                bus_ack_i   = 1'b0;
                bus_err_i   = 1'b0;
                bus_rdata_i = '0;
            end
        end
    end

    // Monitor: counts stall and request cycles per vector, compares when the stall drops.
    int          vec_id   = 0;
    int          done_id  = 0;
    bit          vec_live = 1'b0;
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (vec_live && (vec_id != done_id)) begin
                if (stallreq_o) stall_cnt++;
                if (bus_req_o) begin
                    req_cnt++;
                    cap_sel   = bus_sel_o;
                    cap_we    = bus_we_o;
                    cap_addr  = bus_addr_o;
                    cap_wdata = bus_wdata_o;
                end
                if (!stallreq_o) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, ".wd"},       32'(wd_o),         32'(e.wd));
                        check({e.name, ".wreg"},     32'(wreg_o),       32'(e.wreg));
                        check({e.name, ".wdata"},    wdata_o,           e.wdata);
                        check({e.name, ".exc"},      excepttype_o,      e.exc);
                        check({e.name, ".badvaddr"}, badvaddr_o,        e.bad);
                        check({e.name, ".stall"},    32'(stall_cnt),    32'(e.stall));
                        check({e.name, ".req"},      32'(req_cnt),      32'(e.req));
                        check({e.name, ".req_idle"}, 32'(bus_req_o),    32'd0);
                        if (e.req > 0) begin
                            check({e.name, ".sel"},  32'(cap_sel),      32'(e.sel));
                            check({e.name, ".we"},   32'(cap_we),       32'(e.we));
                            check({e.name, ".addr"}, cap_addr,          e.baddr);
                            if (e.we) check({e.name, ".bwdata"}, cap_wdata, e.bwdata);
                        end
                    end
                    done_id   = vec_id;
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
            end
        end
    end

    task automatic apply(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [31:0] wdat, input logic [31:0] exc, input logic [4:0] wd,
                         input logic wreg, input int lat, input bit errm,
                         input logic [31:0] rdat, input exp_t e);
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wdata_i = wdat;
        excepttype_i = exc; wd_i = wd; wreg_i = wreg;
        ack_lat = lat; err_mode = errm; rdata_cfg = rdat;
        sb.push_back(e);
        vec_id++;
        vec_live = 1'b1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [31:0] wdat, input logic [31:0] exc, input logic [4:0] wd,
                         input logic wreg, input int lat, input bit errm,
                         input logic [31:0] rdat, input exp_t e);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        apply(op, addr, r2, wdat, exc, wd, wreg, lat, errm, rdat, e);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallreq_o) done = 1'b1;
        end
        if (!done) check({e.name, ".stall_bound"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        aluop_i = OP_LW; mem_addr_i = 32'h100; reg2_i = 32'h5; wdata_i = 32'hFFFF;
        excepttype_i = 32'h10; wd_i = 5'd5; wreg_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.wd",       32'(wd_o),         32'd0);
        check("rst.wreg",     32'(wreg_o),       32'd0);
        check("rst.wdata",    wdata_o,           32'd0);
        check("rst.exc",      excepttype_o,      32'd0);
        check("rst.stall",    32'(stallreq_o),   32'd0);
        check("rst.bus_req",  32'(bus_req_o),    32'd0);
        check("rst.bus_sel",  32'(bus_sel_o),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; aluop_i = OP_ADD; excepttype_i = '0;

        issue(OP_ADD, 32'h3,   32'h0, 32'h11223344, 0, 5'd5, 1'b1, 0, 0, 32'h0,
              mk("pass", 5'd5, 1'b1, 32'h11223344, 0, 0, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_LW,  32'h100, 32'h0, 32'h0, 0, 5'd3, 1'b1, 2, 0, 32'hDEADBEEF,
              mk("lw", 5'd3, 1'b1, 32'hDEADBEEF, 0, 0, 3, 2, 4'b1111, 1'b0, 32'h100, 0));
        issue(OP_LB,  32'h103, 32'h0, 32'h0, 0, 5'd4, 1'b1, 1, 0, 32'h000000F0,
              mk("lb", 5'd4, 1'b1, 32'hFFFFFFF0, 0, 0, 2, 1, 4'b0001, 1'b0, 32'h100, 0));
        issue(OP_LBU, 32'h103, 32'h0, 32'h0, 0, 5'd4, 1'b1, 1, 0, 32'h000000F0,
              mk("lbu", 5'd4, 1'b1, 32'h000000F0, 0, 0, 2, 1, 4'b0001, 1'b0, 32'h100, 0));
        issue(OP_LH,  32'h100, 32'h0, 32'h0, 0, 5'd6, 1'b1, 1, 0, 32'h87654321,
              mk("lh", 5'd6, 1'b1, 32'hFFFF8765, 0, 0, 2, 1, 4'b1100, 1'b0, 32'h100, 0));
        issue(OP_LHU, 32'h102, 32'h0, 32'h0, 0, 5'd6, 1'b1, 1, 0, 32'h87654321,
              mk("lhu", 5'd6, 1'b1, 32'h00004321, 0, 0, 2, 1, 4'b0011, 1'b0, 32'h100, 0));
        issue(OP_SH,  32'h202, 32'h1234ABCD, 32'h0, 0, 5'd0, 1'b0, 1, 0, 32'h0,
              mk("sh", 5'd0, 1'b0, 32'h0, 0, 0, 2, 1, 4'b0011, 1'b1, 32'h200, 32'hABCDABCD));
        issue(OP_SB,  32'h101, 32'h000000A5, 32'h0, 0, 5'd0, 1'b0, 3, 0, 32'h0,
              mk("sb", 5'd0, 1'b0, 32'h0, 0, 0, 4, 3, 4'b0100, 1'b1, 32'h100, 32'hA5A5A5A5));
        issue(OP_SW,  32'h204, 32'hCAFEF00D, 32'h0, 0, 5'd0, 1'b0, 1, 0, 32'h0,
              mk("sw", 5'd0, 1'b0, 32'h0, 0, 0, 2, 1, 4'b1111, 1'b1, 32'h204, 32'hCAFEF00D));
        issue(OP_LW,  32'h101, 32'h0, 32'h99, 0, 5'd7, 1'b1, 1, 0, 32'h0,
              mk("lw_adel", 5'd7, 1'b0, 32'h0, 32'h1000, 32'h101, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_SW,  32'h202, 32'h5, 32'h0, 0, 5'd0, 1'b0, 1, 0, 32'h0,
              mk("sw_ades", 5'd0, 1'b0, 32'h0, 32'h2000, 32'h202, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_LH,  32'h101, 32'h0, 32'h0, 0, 5'd7, 1'b1, 1, 0, 32'h0,
              mk("lh_adel", 5'd7, 1'b0, 32'h0, 32'h1000, 32'h101, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_LL,  32'h40, 32'h0, 32'h0, 0, 5'd8, 1'b1, 1, 0, 32'h00000055,
              mk("ll", 5'd8, 1'b1, 32'h00000055, 0, 0, 2, 1, 4'b1111, 1'b0, 32'h40, 0));
        issue(OP_SC,  32'h40, 32'h0BADC0DE, 32'h0, 0, 5'd9, 1'b1, 1, 0, 32'h0,
              mk("sc_ok", 5'd9, 1'b1, 32'h1, 0, 0, 2, 1, 4'b1111, 1'b1, 32'h40, 32'h0BADC0DE));
        issue(OP_SC,  32'h40, 32'h0BADC0DE, 32'h0, 0, 5'd9, 1'b1, 1, 0, 32'h0,
              mk("sc_fail", 5'd9, 1'b1, 32'h0, 0, 0, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_LW,  32'h100, 32'h0, 32'h77, 32'h8, 5'd2, 1'b1, 1, 0, 32'h0,
              mk("exc_pass", 5'd2, 1'b1, 32'h77, 32'h8, 0, 0, 0, 4'h0, 1'b0, 0, 0));
        issue(OP_LW,  32'h300, 32'h0, 32'h0, 0, 5'd3, 1'b1, 0, 0, 32'h0,
              mk("timeout", 5'd3, 1'b0, 32'h0, 32'h4000, 0, 5, 4, 4'b1111, 1'b0, 32'h300, 0));
        issue(OP_LW,  32'h304, 32'h0, 32'h0, 0, 5'd3, 1'b1, 1, 1, 32'h1234,
              mk("buserr", 5'd3, 1'b0, 32'h0, 32'h4000, 0, 2, 1, 4'b1111, 1'b0, 32'h304, 0));

        // Flush in the second ACCESS cycle of a load that never gets an ack.
        @(posedge clk);
        #1;
        apply(OP_LW, 32'h400, 32'h0, 32'h0, 0, 5'd10, 1'b1, 0, 0, 32'h0,
              mk("flush", 5'd10, 1'b0, 32'h0, 0, 0, 2, 1, 4'b1111, 1'b0, 32'h400, 0));
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; aluop_i = OP_ADD; wreg_i = 1'b0;

        issue(OP_LW,  32'h100, 32'h0, 32'h0, 0, 5'd11, 1'b1, 1, 0, 32'h01020304,
              mk("after_flush", 5'd11, 1'b1, 32'h01020304, 0, 0, 2, 1, 4'b1111, 1'b0, 32'h100, 0));

        @(posedge clk);
        #1;
        aluop_i = OP_ADD;
        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
